// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA geometry, palette constants and map-word layout
package vga_pkg;

  localparam int H_DISP     = 640;
  localparam int V_DISP     = 480;
  localparam int TILE_SHIFT = 3;
  localparam int RGB_W      = 12;
  localparam int TILE_W     = 6;
  localparam int PAL_W      = 2;

  typedef logic [RGB_W-1:0] rgb_t;

  typedef struct packed {
    logic [PAL_W-1:0]  pal;
    logic [TILE_W-1:0] tile;
  } map_word_t;

  localparam rgb_t PAL0 = 12'h00F;  // wall blue
  localparam rgb_t PAL1 = 12'hFFF;  // dots
  localparam rgb_t PAL2 = 12'hFF0;  // pacman
  localparam rgb_t PAL3 = 12'hFA8;  // power pellet
  localparam rgb_t BG   = 12'h000;

  // Palette 3 blinks: blink_off selects the background instead of its colour.
  function automatic rgb_t pal_colour(input logic [PAL_W-1:0] pal, input logic blink_off);
    rgb_t c;
    c = BG;
    case (pal)
      2'd0: c = PAL0;
      2'd1: c = PAL1;
      2'd2: c = PAL2;
      2'd3: c = blink_off ? BG : PAL3;
      default: c = BG;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tile_renderer_frame_timer.sv
// rtl/tile_renderer_frame_timer.sv - vsync falling-edge detect, frame tick and frame counter
module frame_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  input  logic       vsync_in,
  output logic       frame_tick,
  output logic [7:0] frame_cnt
);

  logic       r_vs_prev;
  logic       r_tick;
  logic [7:0] r_cnt;
  logic       w_fall;

  // Previous sample resets high so a low first sample after reset counts as a frame start.
  assign w_fall = pix_ce && r_vs_prev && !vsync_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_prev <= 1'b1;
      r_tick    <= 1'b0;
      r_cnt     <= 8'd0;
    end else begin
      r_tick <= w_fall;
      if (pix_ce) r_vs_prev <= vsync_in;
      if (w_fall) r_cnt <= r_cnt + 8'd1;
    end
  end

  assign frame_tick = r_tick;
  assign frame_cnt  = r_cnt;

endmodule

// File: rtl/tile_renderer.sv
// rtl/tile_renderer.sv - three-stage tile-map/glyph pixel pipeline with aligned sync outputs
module tile_renderer #(
  parameter int MAP_COLS  = 80,
  parameter int MAP_ROWS  = 60,
  parameter int H_DISP    = vga_pkg::H_DISP,
  parameter int V_DISP    = vga_pkg::V_DISP,
  parameter int BLINK_BIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [12:0] map_addr,
  input  logic [7:0]  map_data,
  output logic [8:0]  glyph_addr,
  input  logic [7:0]  glyph_data,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_tick,
  output logic [7:0]  frame_cnt
);

  import vga_pkg::*;

  logic       r_active0, r_active1;
  logic [2:0] r_px0, r_py0, r_px1;
  logic [1:0] r_pal1;
  logic       r_hs0, r_vs0, r_hs1, r_vs1;

  logic       w_active0;
  logic [7:0] w_col, w_row;
  logic [12:0] w_map_addr;
  map_word_t  w_map;
  logic       w_bit;
  rgb_t       w_colour;

  assign w_col      = x[10:TILE_SHIFT];
  assign w_row      = y[10:TILE_SHIFT];
  // Wrapped negatives land far above H_DISP/V_DISP, so a plain unsigned compare covers them.
  assign w_active0  = (x < 11'(H_DISP)) && (y < 11'(V_DISP)) && (w_row < 8'(MAP_ROWS));
  assign w_map_addr = 13'(w_row) * 13'(MAP_COLS) + 13'(w_col);
  assign w_map      = map_word_t'(map_data);
  assign w_bit      = glyph_data[3'd7 - r_px1];

  always_comb begin
    w_colour = BG;
    if (w_bit) w_colour = pal_colour(r_pal1, frame_cnt[BLINK_BIT]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      map_addr   <= 13'd0;
      r_active0  <= 1'b0;
      r_px0      <= 3'd0;
      r_py0      <= 3'd0;
      r_hs0      <= 1'b1;
      r_vs0      <= 1'b1;
      glyph_addr <= 9'd0;
      r_pal1     <= 2'd0;
      r_px1      <= 3'd0;
      r_active1  <= 1'b0;
      r_hs1      <= 1'b1;
      r_vs1      <= 1'b1;
      rgb        <= 12'h000;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
    end else if (pix_ce) begin
      map_addr   <= w_map_addr;
      r_active0  <= w_active0;
      r_px0      <= x[2:0];
      r_py0      <= y[2:0];
      r_hs0      <= hsync_in;
      r_vs0      <= vsync_in;

      glyph_addr <= {w_map.tile, r_py0};
      r_pal1     <= w_map.pal;
      r_px1      <= r_px0;
      r_active1  <= r_active0;
      r_hs1      <= r_hs0;
      r_vs1      <= r_vs0;

      rgb        <= r_active1 ? w_colour : 12'h000;
      hsync      <= r_hs1;
      vsync      <= r_vs1;
    end
  end

  frame_timer u_frame_timer (
    .clk        (clk),
    .rst        (rst),
    .pix_ce     (pix_ce),
    .vsync_in   (vsync_in),
    .frame_tick (frame_tick),
    .frame_cnt  (frame_cnt)
  );

endmodule

// File: tb/tb_tile_renderer.sv
// tb/tb_tile_renderer.sv - directed self-checking bench for tile_renderer
module tb_tile_renderer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_ce;
  logic [10:0] x, y;
  logic        hsync_in, vsync_in;
  logic [12:0] map_addr;
  logic [7:0]  map_data;
  logic [8:0]  glyph_addr;
  logic [7:0]  glyph_data;
  logic [11:0] rgb;
  logic        hsync, vsync, frame_tick;
  logic [7:0]  frame_cnt;

  int checks   = 0;
  int failures = 0;

  logic [7:0] map_ram   [0:8191];
  logic [7:0] glyph_rom [0:511];

  assign map_data   = map_ram[map_addr];
  assign glyph_data = glyph_rom[glyph_addr];

  always #5 clk = ~clk;

  tile_renderer dut (
    .clk        (clk),
    .rst        (rst),
    .pix_ce     (pix_ce),
    .x          (x),
    .y          (y),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .map_addr   (map_addr),
    .map_data   (map_data),
    .glyph_addr (glyph_addr),
    .glyph_data (glyph_data),
    .rgb        (rgb),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_tick (frame_tick),
    .frame_cnt  (frame_cnt)
  );

  localparam int N = 9;
  int          vx [N];
  int          vy [N];
  logic [11:0] ve [N];

  int   ticks = 0;
  int   dbl   = 0;
  logic prev_tick = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_step();
    step();
    if (frame_tick) begin
      ticks++;
      if (prev_tick) dbl++;
    end
    prev_tick = frame_tick;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      vsync_in = 1'b0;
      repeat (2) tick_step();
      vsync_in = 1'b1;
      repeat (2) tick_step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int first_low;
    int hs_lows;
    int vs_lows;

    for (int i = 0; i < 8192; i++) map_ram[i] = 8'h00;
    for (int i = 0; i < 512; i++) glyph_rom[i] = 8'h00;
    map_ram[82]   = 8'h45;
    map_ram[335]  = 8'h46;
    map_ram[4802] = 8'h46;
    map_ram[160]  = 8'hC7;
    map_ram[161]  = 8'h07;
    map_ram[162]  = 8'h87;
    glyph_rom[42] = 8'b0010_0000;
    glyph_rom[48] = 8'hFF;
    glyph_rom[50] = 8'hFF;
    glyph_rom[56] = 8'hFF;

    vx = '{16, 18, 19, 2047, 18, 0, 8, 16, 18};
    vy = '{10, 10, 10, 10, 480, 16, 16, 16, 10};
    ve = '{12'h000, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'hFA8, 12'h00F, 12'hFF0, 12'hFFF};

    // reset with pix_ce high
    rst = 1'b1; pix_ce = 1'b1; x = 11'd18; y = 11'd10; hsync_in = 1'b1; vsync_in = 1'b1;
    repeat (3) step();
    chk("rst_rgb", rgb, 12'h000);
    chk("rst_hsync", hsync, 1'b1);
    chk("rst_vsync", vsync, 1'b1);
    chk("rst_frame_cnt", frame_cnt, 8'd0);
    chk("rst_frame_tick", frame_tick, 1'b0);
    chk("rst_map_addr", map_addr, 13'd0);
    chk("rst_glyph_addr", glyph_addr, 9'd0);

    // address generation and decode latency
    rst = 1'b0;
    step();
    chk("map_addr_82", map_addr, 13'd82);
    chk("fill_rgb_1", rgb, 12'h000);
    step();
    chk("glyph_addr_42", glyph_addr, 9'd42);
    chk("fill_rgb_2", rgb, 12'h000);
    step();
    chk("px2_pal1", rgb, 12'hFFF);
    x = 11'd19;
    repeat (3) step();
    chk("px3_bg", rgb, 12'h000);

    // pipelined sequence, pix_ce every clk
    for (int i = 0; i < N + 2; i++) begin
      if (i < N) begin
        x = 11'(vx[i]);
        y = 11'(vy[i]);
      end
      step();
      if (i >= 2) chk($sformatf("seq_ce_all[%0d]", i - 2), rgb, ve[i - 2]);
    end

    // same sequence, pix_ce every 4th clk; junk between strobes must be ignored
    for (int i = 0; i < N + 2; i++) begin
      x = (i < N) ? 11'(vx[i]) : 11'd0;
      y = (i < N) ? 11'(vy[i]) : 11'd0;
      pix_ce = 1'b1;
      step();
      if (i >= 2) chk($sformatf("seq_ce_q[%0d]", i - 2), rgb, ve[i - 2]);
      pix_ce = 1'b0;
      x = 11'd18;
      y = 11'd10;
      repeat (3) step();
      if (i >= 2) chk($sformatf("seq_hold[%0d]", i - 2), rgb, ve[i - 2]);
    end
    pix_ce = 1'b1;

    // 96-strobe hsync pulse, delayed by 3
    first_low = -1;
    hs_lows   = 0;
    vs_lows   = 0;
    for (int k = 0; k < 120; k++) begin
      hsync_in = (k >= 5 && k < 101) ? 1'b0 : 1'b1;
      step();
      if (hsync == 1'b0) begin
        if (first_low < 0) first_low = k;
        hs_lows++;
      end
      if (vsync == 1'b0) vs_lows++;
    end
    hsync_in = 1'b1;
    chk("hsync_first_low", first_low, 32'd7);
    chk("hsync_width", hs_lows, 32'd96);
    chk("vsync_idle", vs_lows, 32'd0);

    // frame timer and palette-3 blink
    frames(15);
    chk("frame_cnt_15", frame_cnt, 8'd15);
    chk("ticks_15", ticks, 32'd15);
    x = 11'd0;
    y = 11'd16;
    repeat (3) step();
    chk("pal3_on", rgb, 12'hFA8);
    frames(1);
    chk("frame_cnt_16", frame_cnt, 8'd16);
    chk("pal3_blink_off", rgb, 12'h000);
    frames(240);
    chk("frame_cnt_wrap", frame_cnt, 8'd0);
    chk("ticks_256", ticks, 32'd256);
    chk("tick_single_clk", dbl, 32'd0);

    // mid-frame reset with syncs low, then a low first sample after release
    x = 11'd18;
    y = 11'd10;
    repeat (3) step();
    chk("pre_reset_rgb", rgb, 12'hFFF);
    rst = 1'b1;
    vsync_in = 1'b0;
    hsync_in = 1'b0;
    step();
    chk("midrst_rgb", rgb, 12'h000);
    chk("midrst_hsync", hsync, 1'b1);
    chk("midrst_vsync", vsync, 1'b1);
    chk("midrst_frame_cnt", frame_cnt, 8'd0);
    chk("midrst_map_addr", map_addr, 13'd0);
    rst = 1'b0;
    step();
    chk("first_low_tick", frame_tick, 1'b1);
    chk("first_low_cnt", frame_cnt, 8'd1);
    step();
    chk("tick_clears", frame_tick, 1'b0);
    chk("cnt_holds", frame_cnt, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
